ax_led_flash: RTL



---
 rtl/ax_led_flash_pkg.sv | 11 +
 rtl/ax_led_flash_if.sv | 26 ++
 rtl/ax_led_flash_ms_timer.sv | 23 ++
 rtl/ax_led_flash.sv | 115 +++++++++++
 4 files changed

// File: rtl/ax_led_flash_pkg.sv
// Shared timing helpers for the ax_* board I/O blocks (LED flasher, button debouncer).
package ax_led_flash_pkg;

    localparam int unsigned US_PER_MS = 1000;

    // Cycles in a millisecond interval at a clock given in MHz; the debouncer uses the same formula.
    function automatic longint unsigned ms_to_cyc(input int ms, input int freq_mhz);
        return longint'(ms) * longint'(US_PER_MS) * longint'(freq_mhz);
    endfunction

endpackage

// File: rtl/ax_led_flash_if.sv
// Request/status bundle between an event source and one LED flasher instance.
interface ax_led_flash_if #(
    parameter int PEND_W = 4
);
    logic              trigger;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output trigger,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  trigger,
        output led_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/ax_led_flash_ms_timer.sv
// Clearable free-running up-counter; done flags the cycle the count equals the terminal value.
module ax_led_flash_ms_timer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] term,
    output logic         done
);
    logic [N-1:0] count;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= count + N'(1);
        end
    end

    assign done = (count == term);
endmodule

// File: rtl/ax_led_flash.sv
// Stretches single-cycle events into fixed on/off LED flashes, replaying requests that arrive mid-flash.
module ax_led_flash
    import ax_led_flash_pkg::*;
#(
    parameter int N          = 32,
    parameter int FREQ       = 50,
    parameter int ON_TIME    = 20,
    parameter int OFF_TIME   = 20,
    parameter int PEND_W     = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    ax_led_flash_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    localparam longint unsigned ON_CYC  = ms_to_cyc(ON_TIME, FREQ);
    localparam longint unsigned OFF_CYC = ms_to_cyc(OFF_TIME, FREQ);
    localparam logic [N-1:0]      ON_TERM  = N'(ON_CYC - 64'd1);
    localparam logic [N-1:0]      OFF_TERM = N'(OFF_CYC - 64'd1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_nxt;
    logic              overflow;
    logic              overflow_nxt;
    logic              led;
    logic              busy;
    logic              done;
    logic              enq;
    logic              deq;
    logic [N-1:0]      term;

    // One timer serves both phases; it is held cleared while idle and restarts at every phase change.
    assign term = (state == S_OFF) ? OFF_TERM : ON_TERM;

    ax_led_flash_ms_timer #(.N(N)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == S_IDLE) || done),
        .term (term),
        .done (done)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        deq       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.trigger || (pending != '0)) begin
                    state_nxt = S_ON;
                    deq       = (pending != '0);
                end
            end
            S_ON: begin
                if (done) state_nxt = S_OFF;
            end
            S_OFF: begin
                if (done) begin
                    if (pending != '0) begin
                        state_nxt = S_ON;
                        deq       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A trigger that can start a flash straight from an empty idle is never queued.
    assign enq = bus.trigger && !((state == S_IDLE) && (pending == '0));

    always_comb begin
        pending_nxt  = pending;
        overflow_nxt = overflow;
        if (enq && !deq) begin
            if (pending == PEND_MAX) begin
                overflow_nxt = 1'b1;
            end else begin
                pending_nxt = pending + PEND_W'(1);
            end
        end else if (deq && !enq) begin
            pending_nxt = pending - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= ACTIVE_LOW;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            led      <= (state_nxt == S_ON) ^ ACTIVE_LOW;
            busy     <= (state_nxt != S_IDLE) || (pending_nxt != '0);
        end
    end

    assign bus.led_out  = led;
    assign bus.busy     = busy;
    assign bus.pending  = pending;
    assign bus.overflow = overflow;
endmodule
